// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: HzCtrl codes for the pipeline registers and the
// MULT/DIV tracker state encodings.
package pipe_pkg;

  // HzCtrl codes understood by the IF/ID and ID/EX registers (2'b11 is never driven)
  localparam logic [1:0] HZ_NORMAL = 2'b00;
  localparam logic [1:0] HZ_FLUSH  = 2'b01;
  localparam logic [1:0] HZ_STALL  = 2'b10;

  // MULT/DIV tracker states
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // Width of the MULT/DIV latency down-counter
  localparam int MD_CNT_W = 8;

  // A source register depends on a destination register unless the destination is $zero.
  function automatic logic reg_dep(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/md_tracker.sv
// MULT/DIV busy-window tracker: md_busy is high for MD_LAT cycles after each md_start,
// and a new md_start while busy restarts the window.
module md_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MD_LAT);

  logic [0:0]          state;
  logic [MD_CNT_W-1:0] md_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            state  <= MD_BUSY;
            md_cnt <= LAT;
          end
        end
        MD_BUSY: begin
          if (md_start) begin
            md_cnt <= LAT;
          end else if (md_cnt == MD_CNT_W'(1)) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
          end else begin
            md_cnt <= md_cnt - MD_CNT_W'(1);
          end
        end
        default: begin
          state  <= MD_IDLE;
          md_cnt <= '0;
        end
      endcase
    end
  end

  // Held low while reset is asserted, even before the first reset edge clears the state.
  assign md_busy = rst && (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives the IF/ID and ID/EX HzCtrl codes and the PC hold,
// resolving load-use, HI/LO waits, taken branches and jumps; keeps stall/flush counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LAT = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RsAddr,
  input  logic [4:0]       IF_ID_RtAddr,
  input  logic             id_uses_rt,
  input  logic             id_reads_hilo,
  input  logic             id_jump,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RtAddr,
  input  logic             ex_branch_taken,
  input  logic             md_start,
  output logic             pc_hold,
  output logic [1:0]       if_id_hz,
  output logic [1:0]       id_ex_hz,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic load_use;
  logic hilo_wait;
  logic stall;

  md_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_tracker (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_busy  (md_busy)
  );

  assign load_use  = ID_EX_MemRead &&
                     (reg_dep(ID_EX_RtAddr, IF_ID_RsAddr) ||
                      (id_uses_rt && reg_dep(ID_EX_RtAddr, IF_ID_RtAddr)));
  assign hilo_wait = md_busy && id_reads_hilo;
  assign stall     = load_use || hilo_wait;

  // A taken branch squashes both younger instructions, so it overrides any stall;
  // a stall in turn holds a jump in ID until its operands are ready.
  // NOTE: every output gets a default first, so no path through the block infers a latch.
  always_comb begin
    pc_hold  = 1'b0;
    if_id_hz = HZ_NORMAL;
    id_ex_hz = HZ_NORMAL;
    if (!rst) begin
      if_id_hz = HZ_FLUSH;
      id_ex_hz = HZ_FLUSH;
    end else if (ex_branch_taken) begin
      if_id_hz = HZ_FLUSH;
      id_ex_hz = HZ_FLUSH;
    end else if (stall) begin
      pc_hold  = 1'b1;
      if_id_hz = HZ_STALL;
      id_ex_hz = HZ_FLUSH;
    end else if (id_jump) begin
      if_id_hz = HZ_FLUSH;
    end
  end

  // Performance counters wrap freely; flush cycles are only counted outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(pc_hold);
      flush_cnt <= flush_cnt + CNT_W'(if_id_hz == HZ_FLUSH);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations per cycle,
// a monitor on the falling edge pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

  localparam int CNT_W  = 4;
  localparam int MD_LAT = 8;
  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] FL = 2'b01;
  localparam logic [1:0] ST = 2'b10;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       hilo;
    logic       jump;
    logic       memrd;
    logic [4:0] ex_rt;
    logic       br;
    logic       mds;
  } stim_t;

  typedef struct {
    string            name;
    logic             pc;
    logic [1:0]       ifh;
    logic [1:0]       exh;
    logic             busy;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       IF_ID_RsAddr, IF_ID_RtAddr, ID_EX_RtAddr;
  logic             id_uses_rt, id_reads_hilo, id_jump, ID_EX_MemRead;
  logic             ex_branch_taken, md_start;
  logic             pc_hold, md_busy;
  logic [1:0]       if_id_hz, id_ex_hz;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t             sb[$];
  int               n_pass  = 0;
  int               n_total = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .IF_ID_RsAddr    (IF_ID_RsAddr),
    .IF_ID_RtAddr    (IF_ID_RtAddr),
    .id_uses_rt      (id_uses_rt),
    .id_reads_hilo   (id_reads_hilo),
    .id_jump         (id_jump),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_RtAddr    (ID_EX_RtAddr),
    .ex_branch_taken (ex_branch_taken),
    .md_start        (md_start),
    .pc_hold         (pc_hold),
    .if_id_hz        (if_id_hz),
    .id_ex_hz        (id_ex_hz),
    .md_busy         (md_busy),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else n_pass++;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, rs: 5'd0, rt: 5'd0, uses_rt: 1'b0, hilo: 1'b0, jump: 1'b0,
          memrd: 1'b0, ex_rt: 5'd0, br: 1'b0, mds: 1'b0};
    return s;
  endfunction

  // Drive one cycle, queue its expected outputs, then advance past the next rising edge.
  task automatic cyc(input string nm, input stim_t s, input logic pc, input logic [1:0] ifh,
                     input logic [1:0] exh, input logic busy);
    exp_t e;
    rst             = s.rst;
    IF_ID_RsAddr    = s.rs;
    IF_ID_RtAddr    = s.rt;
    id_uses_rt      = s.uses_rt;
    id_reads_hilo   = s.hilo;
    id_jump         = s.jump;
    ID_EX_MemRead   = s.memrd;
    ID_EX_RtAddr    = s.ex_rt;
    ex_branch_taken = s.br;
    md_start        = s.mds;
    e = '{name: nm, pc: pc, ifh: ifh, exh: exh, busy: busy, sc: m_stall, fc: m_flush};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!s.rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      m_stall = m_stall + CNT_W'(pc);
      m_flush = m_flush + CNT_W'(ifh == FL);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".pc_hold"},   32'(pc_hold),   32'(e.pc));
      check({e.name, ".if_id_hz"},  32'(if_id_hz),  32'(e.ifh));
      check({e.name, ".id_ex_hz"},  32'(id_ex_hz),  32'(e.exh));
      check({e.name, ".md_busy"},   32'(md_busy),   32'(e.busy));
      check({e.name, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
      check({e.name, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    rst = 1'b0;
    {IF_ID_RsAddr, IF_ID_RtAddr, ID_EX_RtAddr} = '0;
    {id_uses_rt, id_reads_hilo, id_jump, ID_EX_MemRead, ex_branch_taken, md_start} = '0;
    @(posedge clk);
    #1;

    // Reset held, then released with no hazards
    s = idle(); s.rst = 1'b0;
    repeat (3) cyc("rst_low", s, 1'b0, FL, FL, 1'b0);
    s = idle();
    cyc("rst_release", s, 1'b0, NO, NO, 1'b0);

    // Load-use on rs, then the bubble clears it
    s = idle(); s.memrd = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5;
    cyc("lu_rs", s, 1'b1, ST, FL, 1'b0);
    s = idle();
    cyc("lu_bubble", s, 1'b0, NO, NO, 1'b0);
    s = idle(); s.memrd = 1'b1; s.ex_rt = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.uses_rt = 1'b1;
    cyc("lu_r0", s, 1'b0, NO, NO, 1'b0);
    s = idle(); s.memrd = 1'b1; s.ex_rt = 5'd7; s.rs = 5'd3; s.rt = 5'd7; s.uses_rt = 1'b1;
    cyc("lu_rt", s, 1'b1, ST, FL, 1'b0);
    s.uses_rt = 1'b0;
    cyc("lu_rt_unused", s, 1'b0, NO, NO, 1'b0);
    s = idle(); s.memrd = 1'b0; s.ex_rt = 5'd5; s.rs = 5'd5;
    cyc("lu_no_load", s, 1'b0, NO, NO, 1'b0);

    // Branch beats load-use; jump alone flushes IF/ID only
    s = idle(); s.memrd = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5; s.br = 1'b1;
    cyc("br_over_lu", s, 1'b0, FL, FL, 1'b0);
    s = idle();
    cyc("after_br", s, 1'b0, NO, NO, 1'b0);
    s = idle(); s.jump = 1'b1;
    cyc("jump", s, 1'b0, FL, NO, 1'b0);

    // MULT/DIV: 8-cycle HI/LO wait
    s = idle(); s.mds = 1'b1;
    cyc("md_start", s, 1'b0, NO, NO, 1'b0);
    s = idle(); s.hilo = 1'b1;
    for (int i = 1; i <= MD_LAT; i++) cyc($sformatf("hilo_wait%0d", i), s, 1'b1, ST, FL, 1'b1);
    cyc("hilo_done", s, 1'b0, NO, NO, 1'b0);

    // Second md_start in cycle 4 extends the window to 12 cycles
    s = idle(); s.mds = 1'b1;
    cyc("md_start2", s, 1'b0, NO, NO, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      s = idle(); s.hilo = 1'b1; s.mds = (i == 4);
      cyc($sformatf("md_ext%0d", i), s, 1'b1, ST, FL, 1'b1);
    end
    s = idle(); s.hilo = 1'b1;
    cyc("md_ext_done", s, 1'b0, NO, NO, 1'b0);

    // Jump stalled behind a HI/LO wait flushes IF/ID only once the wait clears
    s = idle(); s.mds = 1'b1;
    cyc("md_start3", s, 1'b0, NO, NO, 1'b0);
    s = idle(); s.hilo = 1'b1; s.jump = 1'b1;
    for (int i = 1; i <= MD_LAT; i++) cyc($sformatf("jump_wait%0d", i), s, 1'b1, ST, FL, 1'b1);
    cyc("jump_release", s, 1'b0, FL, NO, 1'b0);

    // A taken branch does not cancel a running MULT/DIV
    s = idle(); s.mds = 1'b1;
    cyc("md_start4", s, 1'b0, NO, NO, 1'b0);
    s = idle(); s.hilo = 1'b1; s.br = 1'b1;
    cyc("br_in_busy", s, 1'b0, FL, FL, 1'b1);
    s = idle(); s.hilo = 1'b1;
    for (int i = 2; i <= MD_LAT; i++) cyc($sformatf("busy_after_br%0d", i), s, 1'b1, ST, FL, 1'b1);
    s = idle();
    cyc("busy_after_br_done", s, 1'b0, NO, NO, 1'b0);

    // Reset in the middle of a MULT/DIV abandons the busy window
    s = idle(); s.mds = 1'b1;
    cyc("md_start5", s, 1'b0, NO, NO, 1'b0);
    s = idle(); s.hilo = 1'b1;
    repeat (2) cyc("pre_rst_wait", s, 1'b1, ST, FL, 1'b1);
    s.rst = 1'b0;
    cyc("rst_mid_md", s, 1'b0, FL, FL, 1'b0);
    s.rst = 1'b1;
    cyc("post_rst_no_wait", s, 1'b0, NO, NO, 1'b0);

    // 17 stall cycles on a 4-bit counter wrap to 1
    s = idle(); s.rst = 1'b0;
    cyc("rst_wrap", s, 1'b0, FL, FL, 1'b0);
    s = idle(); s.memrd = 1'b1; s.ex_rt = 5'd9; s.rs = 5'd9;
    for (int i = 1; i <= 17; i++) cyc($sformatf("wrap_stall%0d", i), s, 1'b1, ST, FL, 1'b0);
    check("wrap_stall_cnt", 32'(stall_cnt), 32'd1);
    s = idle();
    cyc("wrap_idle", s, 1'b0, NO, NO, 1'b0);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_total++;
    if (sb.size() != 0) $display("FAIL drain: got %0d pending expected 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
